prog_loader: RTL
================

Name: prog_loader

Overview:
- Byte-stream program loader that sits directly upstream of the 8-bit accumulator-style core.
- Receives a framed program image over a valid/ready byte interface and writes it into the core's 32-byte instruction/data memory through a write port.
- Holds the core stalled (cpu_hold) until a frame has been received and its checksum verified.
- Supports reloading at any time by sending a new frame.

Parameters:
- MEM_DEPTH, 32, number of memory bytes; maximum legal frame length.
- ADDR_W, 5, memory address width; must satisfy 2**ADDR_W >= MEM_DEPTH.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 255, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  write data.
- cpu_hold  output  1  core stall / PC-reset request.
- done  output  1  last frame loaded and verified.
- err  output  1  last frame rejected.
- load_len  output  6  byte count of last accepted frame.

Behaviour:
- Reset: clock is clk; reset rst_n is asynchronous, active-high.
  - Reset values: state=SYNC, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, load_len=0, in_ready=1.
  - Reset mid-frame abandons the frame. Bytes already written stay in memory, but cpu_hold remains 1.
- Accept rule: a byte is consumed on a rising clk when in_valid && in_ready.
  - in_ready is 1 in every state; the loader never back-pressures.
  - in_data is ignored when in_valid=0.
- States and transitions:
  - SYNC: on accept of SYNC_BYTE -> LEN; clear err and done; set cpu_hold=1; reset running sum to 0. Other bytes are discarded with no flag change.
  - LEN: accepted byte L. If 1 <= L <= MEM_DEPTH: store L, set addr counter=0 -> DATA. Otherwise (L=0 or L>MEM_DEPTH): err=1 -> SYNC.
  - DATA: each accepted byte D is written at the current addr counter.
    - Next cycle: mem_we=1, mem_addr=counter, mem_wdata=D, so write latency is 1 cycle after accept.
    - sum <= sum + D (mod 256); counter increments.
    - After the L-th byte -> CSUM.
  - CSUM: accepted byte C.
    - If (sum + C) mod 256 == 0: done=1, cpu_hold=0, load_len=L -> SYNC.
    - Otherwise: err=1, cpu_hold stays 1 -> SYNC.
- Flag behaviour:
  - done and err are sticky until the next SYNC_BYTE is accepted in SYNC. Both are never 1 together.
  - cpu_hold falls in the cycle after the checksum accept.
  - cpu_hold rises in the cycle after the sync byte of a new frame is accepted.
- mem_we is never high for more than one cycle per data byte. It is 0 in all other cycles, and mem_addr/mem_wdata hold their last values.
- A SYNC_BYTE value arriving in LEN/DATA/CSUM is treated as ordinary payload, not as a restart.
- Frames shorter than MEM_DEPTH leave upper memory bytes untouched.
- The address counter never wraps: the length check bounds it to MEM_DEPTH-1.

Optional Feature:
- Macro: PROG_LOADER_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs in LEN, DATA and CSUM; it resets on every accepted byte.
  - When the counter reaches TIMEOUT_CYC without an accept: err=1, cpu_hold stays 1, state -> SYNC.
  - The counter is held at 0 in SYNC.
- Without the macro: no counter exists, and the loader waits indefinitely mid-frame.

Test Plan:
1. Reset, then send A5, 03, 11, 22, 33, 9A (sum 0x66 + 0x9A = 0x100) -> three mem_we pulses: addr0=0x11, addr1=0x22, addr2=0x33. Then done=1, err=0, cpu_hold=0, load_len=3.
2. Send A5, 02, 10, 20, 00 (bad checksum) -> two writes occur, then err=1, done=0, cpu_hold=1. A following A5 clears err.
3. Send A5, 00 and separately A5, 21 (33 > 32) -> err=1 immediately after the length byte, no mem_we pulses, state back to SYNC.
4. Send noise 00, FF, 5A, then a valid 1-byte frame A5, 01, 80, 80 -> noise is ignored; one write at addr0=0x80; done=1.
5. Full 32-byte frame with data 0..31 and checksum 0x10 (sum 0x1F0) -> 32 writes to addr 0..31, done=1, load_len=32. Assert rst_n mid-way through a second frame -> cpu_hold=1, done=0, err=0.
6. With PROG_LOADER_TIMEOUT_EN and TIMEOUT_CYC=8: send A5, 04, 01, then hold in_valid=0 for 8 cycles -> err=1, cpu_hold=1. A fresh valid frame then loads and sets done=1.

Source files
------------

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, LEN, L data bytes, checksum byte.
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter int         MEM_DEPTH   = 32,
    parameter int         ADDR_W      = 5,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [5:0]        load_len
);

    typedef enum logic [1:0] {S_SYNC, S_LEN, S_DATA, S_CSUM} state_t;

    state_t state, state_nxt;

    logic [5:0]        len, len_nxt;
    logic [5:0]        cnt, cnt_nxt;
    logic [7:0]        sum, sum_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [7:0]        mem_wdata_nxt;
    logic              cpu_hold_nxt, done_nxt, err_nxt;
    logic [5:0]        load_len_nxt;

    logic acc, len_ok, sum_ok, last, tmo;

    assign in_ready = 1'b1;
    assign acc      = in_valid && in_ready;
    assign len_ok   = (in_data != 8'd0) && (in_data <= 8'(MEM_DEPTH));
    assign sum_ok   = (8'(sum + in_data) == 8'd0);
    assign last     = (6'(cnt + 6'd1) == len);

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle;

    // Fires on the TIMEOUT_CYC-th consecutive cycle without an accepted byte.
    assign tmo = (state != S_SYNC) && !acc && (idle == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            idle <= '0;
        else if (state == S_SYNC || acc || tmo)
            idle <= '0;
        else
            idle <= idle + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state <= S_SYNC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tmo)
            state_nxt = S_SYNC;
        else if (acc) begin
            case (state)
                S_SYNC:  if (in_data == SYNC_BYTE) state_nxt = S_LEN;
                S_LEN:   state_nxt = len_ok ? S_DATA : S_SYNC;
                S_DATA:  if (last) state_nxt = S_CSUM;
                S_CSUM:  state_nxt = S_SYNC;
                default: state_nxt = S_SYNC;
            endcase
        end
    end

    always_comb begin
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        cpu_hold_nxt  = cpu_hold;
        done_nxt      = done;
        err_nxt       = err;
        load_len_nxt  = load_len;
        len_nxt       = len;
        cnt_nxt       = cnt;
        sum_nxt       = sum;
        if (tmo)
            err_nxt = 1'b1;
        else if (acc) begin
            case (state)
                S_SYNC: begin
                    if (in_data == SYNC_BYTE) begin
                        err_nxt      = 1'b0;
                        done_nxt     = 1'b0;
                        cpu_hold_nxt = 1'b1;
                        sum_nxt      = 8'd0;
                    end
                end
                S_LEN: begin
                    if (len_ok) begin
                        len_nxt = in_data[5:0];
                        cnt_nxt = 6'd0;
                    end else
                        err_nxt = 1'b1;
                end
                S_DATA: begin
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = cnt[ADDR_W-1:0];
                    mem_wdata_nxt = in_data;
                    sum_nxt       = sum + in_data;
                    cnt_nxt       = cnt + 6'd1;
                end
                S_CSUM: begin
                    if (sum_ok) begin
                        done_nxt     = 1'b1;
                        cpu_hold_nxt = 1'b0;
                        load_len_nxt = len;
                    end else
                        err_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            load_len  <= 6'd0;
            len       <= 6'd0;
            cnt       <= 6'd0;
            sum       <= 8'd0;
        end else begin
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            cpu_hold  <= cpu_hold_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            load_len  <= load_len_nxt;
            len       <= len_nxt;
            cnt       <= cnt_nxt;
            sum       <= sum_nxt;
        end
    end

endmodule
